zeroriscy_regfile_dump: RTL

//  Reader-side companion to the latch-based register file: on request, walks every

---
 rtl/zeroriscy_regfile_dump.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/zeroriscy_regfile_dump.sv
// Register-file dump engine: walks x0..x(N-1) through a borrowed read port and streams
// (addr, data) over valid/ready. Committed writes are snooped so emitted data is never stale.
module zeroriscy_regfile_dump #(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  port_req_o,
  input  logic                  port_gnt_i,
  output logic [4:0]            raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  snoop_we_i,
  input  logic [4:0]            snoop_waddr_i,
  input  logic [DATA_WIDTH-1:0] snoop_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4:0]            out_addr_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  localparam int unsigned NUM_WORDS = RV32E ? 16 : 32;
  localparam logic [5:0]  CNT_END   = 6'(NUM_WORDS);
  localparam logic [4:0]  ADDR_MASK = RV32E ? 5'h0F : 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [4:0]            out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  done_q, done_d;

  logic                  more_words;
  logic                  port_req;
  logic                  accept;
  logic                  capture;
  logic [4:0]            raddr;
  logic [4:0]            snoop_addr;
  logic                  rd_snoop_hit;
  logic                  hold_snoop_hit;
  logic [DATA_WIDTH-1:0] fetch_data;

  // cnt counts up to NUM_WORDS; once it gets there the word in the buffer is the last one.
  assign more_words = (cnt_q != CNT_END);
  assign raddr      = cnt_q[4:0] & ADDR_MASK;
  assign snoop_addr = snoop_waddr_i & ADDR_MASK;

  assign port_req = (state_q == FETCH) || ((state_q == SEND) && more_words);
  assign accept   = (state_q == SEND) && out_ready_i;
  assign capture  = port_req && port_gnt_i &&
                    ((state_q == FETCH) || (accept && more_words));

  // A write committing in the capture cycle is not yet visible on rdata_i.
  assign rd_snoop_hit   = snoop_we_i && (snoop_addr == raddr) && (snoop_addr != 5'd0);
  assign hold_snoop_hit = snoop_we_i && (snoop_addr == out_addr_q) && (snoop_addr != 5'd0);

  always_comb begin
    fetch_data = rdata_i;
    if (raddr == 5'd0) begin
      fetch_data = '0;
    end else if (rd_snoop_hit) begin
      fetch_data = snoop_wdata_i;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (capture) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (!more_words) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else if (!capture) begin
            state_d = FETCH;
          end
        end else if (hold_snoop_hit) begin
          out_data_d = snoop_wdata_i;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      out_data_d = fetch_data;
      out_addr_d = raddr;
      cnt_d      = cnt_q + 6'd1;
    end

    // Abort outranks everything else, including a start or a final accept in the same cycle.
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign port_req_o  = port_req;
  assign raddr_o     = raddr;
  assign out_valid_o = (state_q == SEND);
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;

endmodule
